imem_fetch_port: RTL and testbench

Parametrised, clocked successor to the combinational instruction memory: a word-organised, byte-addressed, little-endian instruction store behind a valid/ready fetch handshake. It adds programmable wait states, alignment and range fault reporting, and a word-wide program-load port. It sits between the PC/fetch stage and decode; the fetch stage issues byte addresses and stalls on `req_ready`/`rsp_valid`.

---
 rtl/imem_pkg.sv | 25 ++
 rtl/imem_word_array.sv | 36 +++
 rtl/imem_fetch_port.sv | 120 ++++++++++++
 tb/tb_imem_fetch_port.sv | 343 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/imem_pkg.sv
// Shared types and constants for the instruction fetch port.
package imem_pkg;

    typedef enum logic [1:0] {
        NONE         = 2'd0,
        MISALIGNED   = 2'd1,
        OUT_OF_RANGE = 2'd2
    } fault_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    // Misalignment outranks range so a bad low address never touches the array.
    function automatic fault_t classify(input logic [1:0] lsb, input logic oor);
        if (lsb != 2'b00) return MISALIGNED;
        if (oor) return OUT_OF_RANGE;
        return NONE;
    endfunction

endpackage

// File: rtl/imem_word_array.sv
// Word store: one synchronous write port, one synchronous read port with a reset output register.
// Latency: read data valid the cycle after rd_en; writes land on the enabling edge.
// Backpressure: none; out-of-range writes are dropped, reads are old-data on same-edge collision.
module imem_word_array
    import imem_pkg::*;
#(
    parameter int ADDR_WIDTH  = 16,
    parameter int DEPTH_WORDS = 1024,
    parameter     INIT_FILE   = "",
    parameter int IW          = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  wr_en,
    input  logic [ADDR_WIDTH-3:0] wr_addr,
    input  logic [31:0]           wr_data,
    input  logic                  rd_en,
    input  logic [IW-1:0]         rd_addr,
    output logic [31:0]           rd_data
);

    logic [31:0] mem [DEPTH_WORDS];
    logic        wr_ok;

    assign wr_ok = wr_en && (32'(wr_addr) < DEPTH_WORDS);

    always_ff @(posedge clk) begin
        if (wr_ok) mem[wr_addr[IW-1:0]] <= wr_data;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)     rd_data <= '0;
        else if (rd_en) rd_data <= mem[rd_addr];
    end

endmodule

// File: rtl/imem_fetch_port.sv
// Clocked instruction fetch port: byte-addressed little-endian words behind valid/ready.
// Latency: rsp_valid rises WAIT_STATES+1 cycles after the accepting cycle.
// Backpressure: response held stable until rsp_ready; no new request accepted until then.
module imem_fetch_port
    import imem_pkg::*;
#(
    parameter int ADDR_WIDTH  = 16,
    parameter int DEPTH_WORDS = 1024,
    parameter int WAIT_STATES = 1,
    parameter     INIT_FILE   = ""
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [31:0]           rsp_instr,
    output logic [ADDR_WIDTH-1:0] rsp_addr,
    output logic [1:0]            rsp_fault,
    input  logic                  load_en,
    input  logic [ADDR_WIDTH-3:0] load_word_addr,
    input  logic [31:0]           load_data,
    output logic                  busy
);

    localparam int                    IW      = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam logic [3:0]            WS      = 4'(WAIT_STATES);
    localparam logic [ADDR_WIDTH-1:0] DEPTH_L = ADDR_WIDTH'(DEPTH_WORDS);

    state_t                state;
    logic [3:0]            cnt;
    logic [ADDR_WIDTH-1:0] addr_q;
    fault_t                fault_q;
    logic [31:0]           rd_data;

    logic                  accept;
    logic                  enter_resp;
    logic                  rd_en;
    logic [ADDR_WIDTH-1:0] cur_addr;
    fault_t                cur_fault;

    assign req_ready = rst_n && (state == IDLE) && !load_en;
    assign accept    = req_valid && req_ready;

    // With zero wait states the read happens on the accept edge, before addr_q is loaded.
    assign cur_addr   = (state == IDLE) ? req_addr : addr_q;
    assign cur_fault  = classify(cur_addr[1:0], {2'b00, cur_addr[ADDR_WIDTH-1:2]} >= DEPTH_L);
    assign enter_resp = (accept && (WS == 4'd0)) || ((state == WAIT) && (cnt == 4'd1));
    assign rd_en      = enter_resp && (cur_fault == NONE);

    imem_word_array #(
        .ADDR_WIDTH  (ADDR_WIDTH),
        .DEPTH_WORDS (DEPTH_WORDS),
        .INIT_FILE   (INIT_FILE),
        .IW          (IW)
    ) u_array (
        .clk     (clk),
        .rst_n   (rst_n),
        .wr_en   (load_en),
        .wr_addr (load_word_addr),
        .wr_data (load_data),
        .rd_en   (rd_en),
        .rd_addr (cur_addr[IW+1:2]),
        .rd_data (rd_data)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            cnt       <= '0;
            addr_q    <= '0;
            fault_q   <= NONE;
            rsp_valid <= 1'b0;
            rsp_addr  <= '0;
            busy      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        addr_q <= req_addr;
                        cnt    <= WS;
                        busy   <= 1'b1;
                        if (WS == 4'd0) begin
                            state     <= RESP;
                            rsp_valid <= 1'b1;
                            rsp_addr  <= req_addr;
                            fault_q   <= cur_fault;
                        end else begin
                            state <= WAIT;
                        end
                    end
                end
                WAIT: begin
                    if (cnt == 4'd1) begin
                        state     <= RESP;
                        rsp_valid <= 1'b1;
                        rsp_addr  <= addr_q;
                        fault_q   <= cur_fault;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                RESP: begin
                    if (rsp_ready) begin
                        state     <= IDLE;
                        rsp_valid <= 1'b0;
                        busy      <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign rsp_fault = fault_q;
    assign rsp_instr = (fault_q != NONE) ? NOP_INSTR : rd_data;

endmodule

// File: tb/tb_imem_fetch_port.sv
// Bench for imem_fetch_port: two instances (0 and 1 wait states) share stimulus and a
// transaction-level model; directed literal checks are queued into the single compare process.
module tb_imem_fetch_port;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid = 1'b0;
    logic [15:0] req_addr = '0;
    logic        rsp_ready = 1'b0;
    logic        load_en = 1'b0;
    logic [13:0] load_word_addr = '0;
    logic [31:0] load_data = '0;

    logic [1:0]  req_ready_w;
    logic [1:0]  rsp_valid_w;
    logic [1:0]  busy_w;
    logic [31:0] instr_w [2];
    logic [15:0] raddr_w [2];
    logic [1:0]  fault_w [2];

    always #5 clk = ~clk;

    imem_fetch_port #(.ADDR_WIDTH(16), .DEPTH_WORDS(1024), .WAIT_STATES(0), .INIT_FILE("")) dut0 (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready_w[0]),
        .req_addr(req_addr), .rsp_valid(rsp_valid_w[0]), .rsp_ready(rsp_ready),
        .rsp_instr(instr_w[0]), .rsp_addr(raddr_w[0]), .rsp_fault(fault_w[0]),
        .load_en(load_en), .load_word_addr(load_word_addr), .load_data(load_data),
        .busy(busy_w[0])
    );

    imem_fetch_port #(.ADDR_WIDTH(16), .DEPTH_WORDS(1024), .WAIT_STATES(1), .INIT_FILE("")) dut1 (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready_w[1]),
        .req_addr(req_addr), .rsp_valid(rsp_valid_w[1]), .rsp_ready(rsp_ready),
        .rsp_instr(instr_w[1]), .rsp_addr(raddr_w[1]), .rsp_fault(fault_w[1]),
        .load_en(load_en), .load_word_addr(load_word_addr), .load_data(load_data),
        .busy(busy_w[1])
    );

    // ---------------- transaction-level model ----------------
    // Instance i has i wait states: a request accepted at cycle n is read at cycle n+i.
    logic [31:0] mm [32];
    logic [1:0]  m_valid = '0;
    logic [1:0]  m_pend = '0;
    int          m_rdcyc [2];
    logic [15:0] m_addr [2];
    logic [15:0] m_raddr [2] = '{16'h0, 16'h0};
    logic [31:0] m_instr [2] = '{32'h0, 32'h0};
    logic [1:0]  m_fault [2] = '{2'h0, 2'h0};
    int          cyc = 0;

    function automatic logic [1:0] fcode(input logic [15:0] a);
        if (a[1:0] != 2'b00) return 2'd1;
        if (a >= 16'h1000) return 2'd2;
        return 2'd0;
    endfunction

    function automatic logic [31:0] fdata(input logic [15:0] a);
        if (fcode(a) != 2'd0) return NOP;
        return mm[a[6:2]];
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_valid <= '0;
            m_pend  <= '0;
            for (int i = 0; i < 2; i++) begin
                m_instr[i] <= '0;
                m_raddr[i] <= '0;
                m_fault[i] <= '0;
            end
        end else begin
            for (int i = 0; i < 2; i++) begin
                if (m_valid[i]) begin
                    if (rsp_ready) m_valid[i] <= 1'b0;
                end else if (m_pend[i]) begin
                    if (cyc == m_rdcyc[i]) begin
                        m_pend[i]  <= 1'b0;
                        m_valid[i] <= 1'b1;
                        m_instr[i] <= fdata(m_addr[i]);
                        m_raddr[i] <= m_addr[i];
                        m_fault[i] <= fcode(m_addr[i]);
                    end
                end else if (req_valid && !load_en) begin
                    if (i == 0) begin
                        m_valid[i] <= 1'b1;
                        m_instr[i] <= fdata(req_addr);
                        m_raddr[i] <= req_addr;
                        m_fault[i] <= fcode(req_addr);
                    end else begin
                        m_pend[i]  <= 1'b1;
                        m_rdcyc[i] <= cyc + i;
                        m_addr[i]  <= req_addr;
                    end
                end
            end
            if (load_en && load_word_addr < 14'd32) mm[load_word_addr[4:0]] <= load_data;
            cyc <= cyc + 1;
        end
    end

    // ---------------- compare process ----------------
    typedef struct {
        string       nm;
        logic [31:0] act;
        logic [31:0] exp;
    } lit_t;

    lit_t lq[$];
    int   ntot = 0;
    int   nbad = 0;

    task automatic lit(input string nm, input logic [31:0] act, input logic [31:0] exp);
        lit_t it;
        it.nm  = nm;
        it.act = act;
        it.exp = exp;
        lq.push_back(it);
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        ntot++;
        if (act !== exp) begin
            nbad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        for (int i = 0; i < 2; i++) begin
            chk($sformatf("req_ready%0d", i), 32'(req_ready_w[i]),
                32'(rst_n && !m_valid[i] && !m_pend[i] && !load_en));
            chk($sformatf("rsp_valid%0d", i), 32'(rsp_valid_w[i]), 32'(m_valid[i]));
            chk($sformatf("busy%0d", i), 32'(busy_w[i]), 32'(m_valid[i] || m_pend[i]));
            if (m_valid[i] || !rst_n) begin
                chk($sformatf("rsp_instr%0d", i), instr_w[i], m_instr[i]);
                chk($sformatf("rsp_addr%0d", i), 32'(raddr_w[i]), 32'(m_raddr[i]));
                chk($sformatf("rsp_fault%0d", i), 32'(fault_w[i]), 32'(m_fault[i]));
            end
        end
        while (lq.size() > 0) begin
            lit_t it;
            it = lq.pop_front();
            chk(it.nm, it.act, it.exp);
        end
    end

    // ---------------- directed helpers ----------------
    task automatic load_word(input logic [13:0] w, input logic [31:0] d);
        @(posedge clk); #1;
        load_en = 1'b1;
        load_word_addr = w;
        load_data = d;
        @(posedge clk); #1;
        load_en = 1'b0;
    endtask

    // One request; checks 0-wait instance one cycle after accept, 1-wait instance two cycles after.
    task automatic fetch_one(input logic [15:0] a, input logic [31:0] ei, input logic [1:0] ef);
        @(posedge clk); #1;
        req_valid = 1'b1;
        req_addr  = a;
        rsp_ready = 1'b1;
        @(negedge clk);
        lit("f_ready0", 32'(req_ready_w[0]), 32'd1);
        lit("f_ready1", 32'(req_ready_w[1]), 32'd1);
        @(posedge clk); #1;
        req_valid = 1'b0;
        @(negedge clk);
        lit("f_valid0", 32'(rsp_valid_w[0]), 32'd1);
        lit("f_instr0", instr_w[0], ei);
        lit("f_fault0", 32'(fault_w[0]), 32'(ef));
        lit("f_addr0", 32'(raddr_w[0]), 32'(a));
        lit("f_valid1_early", 32'(rsp_valid_w[1]), 32'd0);
        lit("f_busy1", 32'(busy_w[1]), 32'd1);
        @(posedge clk); #1;
        @(negedge clk);
        lit("f_valid1", 32'(rsp_valid_w[1]), 32'd1);
        lit("f_instr1", instr_w[1], ei);
        lit("f_fault1", 32'(fault_w[1]), 32'(ef));
        lit("f_addr1", 32'(raddr_w[1]), 32'(a));
        lit("f_valid0_done", 32'(rsp_valid_w[0]), 32'd0);
        @(posedge clk);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int r;
        int w;

        repeat (2) @(negedge clk);
        lit("rst_ready0", 32'(req_ready_w[0]), 32'd0);
        lit("rst_ready1", 32'(req_ready_w[1]), 32'd0);
        lit("rst_instr1", instr_w[1], 32'd0);
        lit("rst_busy1", 32'(busy_w[1]), 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        lit("post_rst_ready1", 32'(req_ready_w[1]), 32'd1);

        // Preload words 0..31; words 0..2 get recognisable values.
        for (int i = 0; i < 32; i++) begin
            @(posedge clk); #1;
            load_en = 1'b1;
            load_word_addr = 14'(i);
            load_data = (i == 0) ? 32'hCD01_BC0F : (i == 1) ? 32'h4433_2211 :
                        (i == 2) ? 32'hDEAD_BEEF : $urandom;
        end
        @(posedge clk); #1;
        load_en = 1'b0;

        fetch_one(16'h0000, 32'hCD01_BC0F, 2'd0);
        fetch_one(16'h0006, NOP, 2'd1);
        fetch_one(16'h1000, NOP, 2'd2);
        fetch_one(16'h1002, NOP, 2'd1);

        // Out-of-range load must not alias onto word 0.
        load_word(14'h0400, 32'hBAD0_BAD0);
        fetch_one(16'h0000, 32'hCD01_BC0F, 2'd0);

        // Backpressure with a load to the held word.
        @(posedge clk); #1;
        req_valid = 1'b1; req_addr = 16'h0004; rsp_ready = 1'b0;
        @(posedge clk); #1;
        req_valid = 1'b0;
        @(posedge clk); #1;
        load_en = 1'b1; load_word_addr = 14'd1; load_data = 32'h5566_7788;
        @(posedge clk); #1;
        load_en = 1'b0;
        repeat (4) begin
            @(negedge clk);
            lit("bp_valid0", 32'(rsp_valid_w[0]), 32'd1);
            lit("bp_valid1", 32'(rsp_valid_w[1]), 32'd1);
            lit("bp_instr0", instr_w[0], 32'h4433_2211);
            lit("bp_instr1", instr_w[1], 32'h4433_2211);
            lit("bp_addr1", 32'(raddr_w[1]), 32'd4);
            lit("bp_ready1", 32'(req_ready_w[1]), 32'd0);
        end
        @(posedge clk); #1;
        rsp_ready = 1'b1;
        @(posedge clk);
        fetch_one(16'h0004, 32'h5566_7788, 2'd0);

        // Load in IDLE blocks acceptance.
        @(posedge clk); #1;
        req_valid = 1'b1; req_addr = 16'h0008; rsp_ready = 1'b1;
        load_en = 1'b1; load_word_addr = 14'd3; load_data = $urandom;
        @(negedge clk);
        lit("ld_ready0", 32'(req_ready_w[0]), 32'd0);
        lit("ld_ready1", 32'(req_ready_w[1]), 32'd0);
        @(posedge clk); #1;
        req_valid = 1'b0; load_en = 1'b0;
        @(negedge clk);
        lit("ld_busy0", 32'(busy_w[0]), 32'd0);
        lit("ld_busy1", 32'(busy_w[1]), 32'd0);

        // Load on the RESP-entry edge of the 1-wait instance returns old data.
        @(posedge clk); #1;
        req_valid = 1'b1; req_addr = 16'h0008; rsp_ready = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0;
        load_en = 1'b1; load_word_addr = 14'd2; load_data = 32'h0BAD_F00D;
        @(negedge clk);
        lit("col_instr0", instr_w[0], 32'hDEAD_BEEF);
        @(posedge clk); #1;
        load_en = 1'b0;
        @(negedge clk);
        lit("col_valid1", 32'(rsp_valid_w[1]), 32'd1);
        lit("col_instr1", instr_w[1], 32'hDEAD_BEEF);
        @(posedge clk);
        fetch_one(16'h0008, 32'h0BAD_F00D, 2'd0);

        // Back-to-back fetches on the zero-wait instance: 2-cycle spacing.
        @(posedge clk); #1;
        req_valid = 1'b1; req_addr = 16'h0000; rsp_ready = 1'b1;
        @(posedge clk); #1;
        req_addr = 16'h0004;
        @(negedge clk);
        lit("b2b_v0_a", 32'(rsp_valid_w[0]), 32'd1);
        lit("b2b_i0_a", instr_w[0], 32'hCD01_BC0F);
        @(posedge clk); #1;
        @(negedge clk);
        lit("b2b_gap_a", 32'(rsp_valid_w[0]), 32'd0);
        @(posedge clk); #1;
        req_addr = 16'h0008;
        @(negedge clk);
        lit("b2b_v0_b", 32'(rsp_valid_w[0]), 32'd1);
        lit("b2b_i0_b", instr_w[0], 32'h5566_7788);
        @(posedge clk); #1;
        @(negedge clk);
        lit("b2b_gap_b", 32'(rsp_valid_w[0]), 32'd0);
        @(posedge clk); #1;
        req_valid = 1'b0;
        @(negedge clk);
        lit("b2b_v0_c", 32'(rsp_valid_w[0]), 32'd1);
        lit("b2b_i0_c", instr_w[0], 32'h0BAD_F00D);
        repeat (4) @(posedge clk);

        // Reset while the 1-wait instance is in WAIT.
        @(posedge clk); #1;
        req_valid = 1'b1; req_addr = 16'h0000; rsp_ready = 1'b0;
        @(posedge clk); #1;
        req_valid = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        lit("mr_valid0", 32'(rsp_valid_w[0]), 32'd0);
        lit("mr_instr0", instr_w[0], 32'd0);
        lit("mr_addr0", 32'(raddr_w[0]), 32'd0);
        lit("mr_busy1", 32'(busy_w[1]), 32'd0);
        lit("mr_ready1", 32'(req_ready_w[1]), 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1; rsp_ready = 1'b1;
        fetch_one(16'h0000, 32'hCD01_BC0F, 2'd0);

        // Randomized traffic checked by the model.
        for (int n = 0; n < 3000; n++) begin
            @(posedge clk); #1;
            req_valid = ($urandom_range(0, 9) < 7);
            r = $urandom_range(0, 9);
            w = $urandom_range(0, 31);
            if (r < 7)       req_addr = 16'(w * 4);
            else if (r == 7) req_addr = 16'(w * 4 + $urandom_range(1, 3));
            else if (r == 8) req_addr = 16'($urandom_range(1024, 16383) * 4);
            else             req_addr = 16'($urandom_range(1024, 16383) * 4 + 1);
            rsp_ready = ($urandom_range(0, 9) < 6);
            load_en = ($urandom_range(0, 99) < 15);
            load_word_addr = ($urandom_range(0, 7) == 0) ? 14'($urandom_range(1024, 16383))
                                                         : 14'($urandom_range(0, 31));
            load_data = $urandom;
        end

        @(posedge clk); #1;
        req_valid = 1'b0; load_en = 1'b0; rsp_ready = 1'b1;
        repeat (6) @(posedge clk);
        @(negedge clk);
        @(posedge clk);
        $display("test done: total=%0d bad=%0d", ntot, nbad);
        $finish;
    end

endmodule
